// File: rtl/uart_icb_bridge.sv
// uart_icb_bridge: turns framed UART byte commands into single ICB transactions
// and returns a status byte (plus read data) on the UART tx stream.
module uart_icb_bridge #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_vld,
  output logic              rx_rdy,
  input  logic [7:0]        rx_data,
  output logic              tx_vld,
  input  logic              tx_rdy,
  output logic [7:0]        tx_data,
  output logic              icb_cmd_vld,
  input  logic              icb_cmd_rdy,
  output logic              icb_cmd_read,
  output logic [AW-1:0]     icb_cmd_addr,
  output logic [DW-1:0]     icb_cmd_wdata,
  output logic [DW/8-1:0]   icb_cmd_wmask,
  input  logic              icb_rsp_vld,
  output logic              icb_rsp_rdy,
  input  logic [DW-1:0]     icb_rsp_rdata,
  input  logic              icb_rsp_err,
  output logic              busy,
  output logic              proto_err
);

  localparam int unsigned   TW     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT);
  localparam logic [7:0]    OP_WR  = 8'hA5;
  localparam logic [7:0]    OP_RD  = 8'h5A;

  typedef enum logic [2:0] {
    S_OP, S_ADDR, S_DATA, S_CMD, S_RSP, S_STAT, S_RDAT
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [1:0]      r_bcnt;
  logic [TW-1:0]   r_to_cnt;
  logic            r_read;
  logic            r_err;
  logic [31:0]     r_addr;
  logic [DW-1:0]   r_wdata;
  logic [DW-1:0]   r_rdata;
  logic            w_op_ok;
  logic            w_frame_hs;
  logic            w_rdat_hs;
  logic [AW+31:0]  w_addr_ext;

  assign w_op_ok    = (rx_data == OP_WR) || (rx_data == OP_RD);
  // The address field is always 4 bytes; zero-extend or truncate it to AW.
  assign w_addr_ext = {{AW{1'b0}}, r_addr};

  assign icb_cmd_addr  = w_addr_ext[AW-1:0];
  assign icb_cmd_wdata = r_wdata;
  assign icb_cmd_read  = r_read;
  assign icb_cmd_wmask = (r_state == S_CMD && !r_read) ? '1 : '0;
  assign busy          = (r_state != S_OP);

  // Next-state and handshake decode
  always_comb begin
    w_next      = r_state;
    rx_rdy      = 1'b0;
    tx_vld      = 1'b0;
    icb_cmd_vld = 1'b0;
    icb_rsp_rdy = 1'b0;
    proto_err   = 1'b0;
    w_frame_hs  = 1'b0;
    w_rdat_hs   = 1'b0;
    case (r_state)
      S_OP: begin
        rx_rdy = 1'b1;
        if (rx_vld) begin
          if (w_op_ok) w_next = S_ADDR;
          else         proto_err = 1'b1;
        end
      end
      S_ADDR, S_DATA: begin
        rx_rdy = 1'b1;
        if (rx_vld) begin
          w_frame_hs = 1'b1;
          if (r_bcnt == 2'd3) begin
            if (r_state == S_DATA || r_read) w_next = S_CMD;
            else                             w_next = S_DATA;
          end
        end else if (r_to_cnt == TO_MAX) begin
          proto_err = 1'b1;
          w_next    = S_OP;
        end
      end
      S_CMD: begin
        icb_cmd_vld = 1'b1;
        if (icb_cmd_rdy) w_next = S_RSP;
      end
      S_RSP: begin
        icb_rsp_rdy = 1'b1;
        if (icb_rsp_vld) w_next = S_STAT;
      end
      S_STAT: begin
        tx_vld = 1'b1;
        if (tx_rdy) w_next = (r_read && !r_err) ? S_RDAT : S_OP;
      end
      S_RDAT: begin
        tx_vld = 1'b1;
        if (tx_rdy) begin
          w_rdat_hs = 1'b1;
          if (r_bcnt == 2'd3) w_next = S_OP;
        end
      end
      default: w_next = S_OP;
    endcase
  end

  // Reply byte mux: status in S_STAT, read data LSB first in S_RDAT
  always_comb begin
    tx_data = '0;
    if (r_state == S_STAT)      tx_data = {7'd0, r_err};
    else if (r_state == S_RDAT) tx_data = r_rdata[{r_bcnt, 3'b000} +: 8];
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_OP;
    else     r_state <= w_next;
  end

  // Byte counter (cleared on state entry) and inter-byte timeout counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bcnt   <= '0;
      r_to_cnt <= '0;
    end else begin
      if (w_next != r_state)          r_bcnt <= '0;
      else if (w_frame_hs || w_rdat_hs) r_bcnt <= r_bcnt + 2'd1;

      if ((r_state == S_ADDR || r_state == S_DATA) && !w_frame_hs && (w_next == r_state))
        r_to_cnt <= r_to_cnt + TW'(1);
      else
        r_to_cnt <= '0;
    end
  end

  // Frame field capture and ICB response capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_read  <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      if (r_state == S_OP && rx_vld && w_op_ok) r_read <= (rx_data == OP_RD);
      if (r_state == S_ADDR && w_frame_hs)      r_addr <= {rx_data, r_addr[31:8]};
      if (r_state == S_DATA && w_frame_hs)      r_wdata <= {rx_data, r_wdata[DW-1:8]};
      if (r_state == S_RSP && icb_rsp_vld) begin
        r_rdata <= icb_rsp_rdata;
        r_err   <= icb_rsp_err;
      end
    end
  end

endmodule

// File: tb/tb_uart_icb_bridge.sv
// Scoreboard bench for uart_icb_bridge: stimulus pushes expected ICB commands,
// reply bytes and proto_err pulses; monitors pop and compare as the DUT presents them.
module tb_uart_icb_bridge;

  typedef struct packed {
    logic        read;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_vld;
  logic        rx_rdy;
  logic [7:0]  rx_data;
  logic        tx_vld;
  logic        tx_rdy;
  logic [7:0]  tx_data;
  logic        icb_cmd_vld;
  logic        icb_cmd_rdy;
  logic        icb_cmd_read;
  logic [31:0] icb_cmd_addr;
  logic [31:0] icb_cmd_wdata;
  logic [3:0]  icb_cmd_wmask;
  logic        icb_rsp_vld;
  logic        icb_rsp_rdy;
  logic [31:0] icb_rsp_rdata;
  logic        icb_rsp_err;
  logic        busy;
  logic        proto_err;

  int          n_chk = 0;
  int          n_fail = 0;
  cmd_t        exp_cmd[$];
  logic [32:0] rsp_q[$];
  logic [7:0]  exp_tx[$];
  int          exp_perr = 0;
  int unsigned cmd_stall = 0;
  logic        rsp_hold = 1'b0;
  logic        tx_mode = 1'b0;

  uart_icb_bridge #(.AW(32), .DW(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .rx_vld(rx_vld), .rx_rdy(rx_rdy), .rx_data(rx_data),
    .tx_vld(tx_vld), .tx_rdy(tx_rdy), .tx_data(tx_data),
    .icb_cmd_vld(icb_cmd_vld), .icb_cmd_rdy(icb_cmd_rdy), .icb_cmd_read(icb_cmd_read),
    .icb_cmd_addr(icb_cmd_addr), .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wmask(icb_cmd_wmask),
    .icb_rsp_vld(icb_rsp_vld), .icb_rsp_rdy(icb_rsp_rdy), .icb_rsp_rdata(icb_rsp_rdata),
    .icb_rsp_err(icb_rsp_err), .busy(busy), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic exp_icb(input logic rd, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] rdata, input logic err);
    cmd_t c;
    c.read = rd; c.addr = a; c.wdata = d;
    exp_cmd.push_back(c);
    rsp_q.push_back({err, rdata});
  endtask

  task automatic exp_bytes(input logic [7:0] q[$]);
    foreach (q[i]) exp_tx.push_back(q[i]);
  endtask

  // Called at a negedge; returns at the negedge after the byte was taken
  task automatic send_byte(input logic [7:0] b);
    int unsigned n;
    n = 0;
    rx_data = b;
    rx_vld  = 1'b1;
    #1;
    while (!rx_rdy && n < 500) begin
      @(negedge clk); #1;
      n++;
    end
    chk("rx_rdy_wait", rx_rdy, 1);
    @(negedge clk);
    rx_vld = 1'b0;
  endtask

  task automatic send_q(input logic [7:0] q[$]);
    foreach (q[i]) send_byte(q[i]);
  endtask

  task automatic drain(input string name);
    int unsigned n;
    n = 0;
    while ((exp_tx.size() != 0 || exp_cmd.size() != 0) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk(name, exp_tx.size() + exp_cmd.size(), 0);
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rx_rdy"},  rx_rdy, 1);
    chk({tag, "_tx_vld"},  tx_vld, 0);
    chk({tag, "_tx_data"}, tx_data, 0);
    chk({tag, "_cmd_vld"}, icb_cmd_vld, 0);
    chk({tag, "_read"},    icb_cmd_read, 0);
    chk({tag, "_addr"},    icb_cmd_addr, 0);
    chk({tag, "_wdata"},   icb_cmd_wdata, 0);
    chk({tag, "_wmask"},   icb_cmd_wmask, 0);
    chk({tag, "_rsp_rdy"}, icb_rsp_rdy, 0);
    chk({tag, "_busy"},    busy, 0);
    chk({tag, "_perr"},    proto_err, 0);
  endtask

  // ICB slave: optional command stall, one response per accepted command
  initial begin : slave
    logic [32:0] cur;
    logic        pend;
    logic        cmd_fire;
    logic        rsp_fire;
    int unsigned stall;
    cur = '0; pend = 1'b0; cmd_fire = 1'b0; rsp_fire = 1'b0; stall = 0;
    icb_cmd_rdy = 1'b0; icb_rsp_vld = 1'b0; icb_rsp_rdata = '0; icb_rsp_err = 1'b0;
    forever begin
      @(negedge clk); #1;
      if (rst) begin
        pend = 1'b0; stall = 0;
        icb_cmd_rdy = 1'b0; icb_rsp_vld = 1'b0; icb_rsp_rdata = '0; icb_rsp_err = 1'b0;
      end else begin
        if (rsp_fire) pend = 1'b0;
        if (cmd_fire) begin
          pend = 1'b1; stall = 0;
          cur = (rsp_q.size() != 0) ? rsp_q.pop_front() : 33'd0;
        end
        icb_cmd_rdy = 1'b0;
        if (!pend && icb_cmd_vld) begin
          if (stall >= cmd_stall) icb_cmd_rdy = 1'b1;
          else                    stall++;
        end
        icb_rsp_vld   = pend && !rsp_hold;
        icb_rsp_rdata = pend ? cur[31:0] : 32'd0;
        icb_rsp_err   = pend ? cur[32] : 1'b0;
      end
      cmd_fire = icb_cmd_vld && icb_cmd_rdy;
      rsp_fire = icb_rsp_vld && icb_rsp_rdy;
    end
  end

  // tx sink: always ready, or toggling ready for backpressure
  initial begin : sink
    tx_rdy = 1'b1;
    forever begin
      @(negedge clk); #1;
      tx_rdy = tx_mode ? ~tx_rdy : 1'b1;
    end
  end

  // Monitor: compares every ICB command, reply byte and proto_err pulse
  initial begin : monitor
    cmd_t        e;
    logic        stalled;
    logic [31:0] h_addr;
    logic [31:0] h_wdata;
    logic        h_read;
    logic [3:0]  h_mask;
    stalled = 1'b0; h_addr = '0; h_wdata = '0; h_read = 1'b0; h_mask = '0;
    forever begin
      @(negedge clk); #3;
      if (rst) begin
        stalled = 1'b0;
      end else begin
        if (icb_cmd_vld) begin
          if (stalled) begin
            chk("cmd_addr_stable",  icb_cmd_addr,  h_addr);
            chk("cmd_wdata_stable", icb_cmd_wdata, h_wdata);
            chk("cmd_read_stable",  icb_cmd_read,  h_read);
            chk("cmd_wmask_stable", icb_cmd_wmask, h_mask);
          end
          if (icb_cmd_rdy) begin
            stalled = 1'b0;
            chk("cmd_expected", exp_cmd.size() != 0, 1);
            if (exp_cmd.size() != 0) begin
              e = exp_cmd.pop_front();
              chk("cmd_read",  icb_cmd_read, e.read);
              chk("cmd_addr",  icb_cmd_addr, e.addr);
              chk("cmd_wmask", icb_cmd_wmask, e.read ? 4'h0 : 4'hF);
              if (!e.read) chk("cmd_wdata", icb_cmd_wdata, e.wdata);
            end
          end else begin
            stalled = 1'b1;
            h_addr = icb_cmd_addr; h_wdata = icb_cmd_wdata;
            h_read = icb_cmd_read; h_mask = icb_cmd_wmask;
          end
        end else begin
          stalled = 1'b0;
        end
        if (tx_vld && tx_rdy) begin
          chk("tx_expected", exp_tx.size() != 0, 1);
          if (exp_tx.size() != 0) chk("tx_byte", tx_data, exp_tx.pop_front());
        end
        if (proto_err) begin
          chk("perr_expected", exp_perr > 0, 1);
          if (exp_perr > 0) exp_perr--;
        end
      end
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [7:0]  fr[$];
    logic        hit;
    logic        saw_cmd;
    int unsigned cyc;
    int unsigned n;
    rst = 1'b1; rx_vld = 1'b0; rx_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    chk_reset_vals("reset");

    // Write frame
    exp_icb(1'b0, 32'h8000_1000, 32'hDEAD_BEEF, 32'h0, 1'b0);
    fr = '{8'h00}; exp_bytes(fr);
    fr = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h80, 8'hEF, 8'hBE, 8'hAD, 8'hDE}; send_q(fr);
    drain("write_drain");

    // Read frame, good status with 4 data bytes
    exp_icb(1'b1, 32'h8000_0004, 32'h0, 32'h1234_5678, 1'b0);
    fr = '{8'h00, 8'h78, 8'h56, 8'h34, 8'h12}; exp_bytes(fr);
    fr = '{8'h5A, 8'h04, 8'h00, 8'h00, 8'h80}; send_q(fr);
    drain("read_drain");

    // Read with bus error: status only, then a normal write
    exp_icb(1'b1, 32'h0000_0000, 32'h0, 32'hCAFE_F00D, 1'b1);
    fr = '{8'h01}; exp_bytes(fr);
    fr = '{8'h5A, 8'h00, 8'h00, 8'h00, 8'h00}; send_q(fr);
    exp_icb(1'b0, 32'h0000_1234, 32'h4433_2211, 32'h0, 1'b0);
    fr = '{8'h00}; exp_bytes(fr);
    fr = '{8'hA5, 8'h34, 8'h12, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44}; send_q(fr);
    drain("err_drain");

    // Bad opcode dropped, following write unaffected
    exp_perr++;
    send_byte(8'h33);
    exp_icb(1'b0, 32'h1234_5678, 32'h0000_0001, 32'h0, 1'b0);
    fr = '{8'h00}; exp_bytes(fr);
    fr = '{8'hA5, 8'h78, 8'h56, 8'h34, 8'h12, 8'h01, 8'h00, 8'h00, 8'h00}; send_q(fr);
    drain("badop_drain");
    chk("badop_perr_consumed", exp_perr, 0);

    // Inter-byte timeout after a partial frame
    exp_perr++;
    fr = '{8'hA5, 8'h00, 8'h10}; send_q(fr);
    hit = 1'b0; saw_cmd = 1'b0; cyc = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (icb_cmd_vld) saw_cmd = 1'b1;
      if (proto_err) begin
        hit = 1'b1; cyc = i;
        break;
      end
      @(negedge clk);
    end
    chk("timeout_pulse", hit, 1);
    chk("timeout_cycle", cyc, 16);
    @(negedge clk); #1;
    chk("timeout_back_to_op", busy, 0);
    chk("timeout_pulse_width", proto_err, 0);
    chk("timeout_no_cmd", saw_cmd | icb_cmd_vld, 0);
    chk("timeout_perr_consumed", exp_perr, 0);

    // Stalled command and toggling tx ready
    cmd_stall = 5; tx_mode = 1'b1;
    @(negedge clk);
    exp_icb(1'b1, 32'h2000_0010, 32'h0, 32'hA1B2_C3D4, 1'b0);
    fr = '{8'h00, 8'hD4, 8'hC3, 8'hB2, 8'hA1}; exp_bytes(fr);
    fr = '{8'h5A, 8'h10, 8'h00, 8'h00, 8'h20}; send_q(fr);
    drain("stall_drain");
    cmd_stall = 0; tx_mode = 1'b0;
    @(negedge clk);

    // Reset while waiting for the response
    rsp_hold = 1'b1;
    exp_icb(1'b0, 32'h4000_0000, 32'h5555_5555, 32'h0, 1'b0);
    fr = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h40, 8'h55, 8'h55, 8'h55, 8'h55}; send_q(fr);
    n = 0;
    #1;
    while (!icb_rsp_rdy && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    chk("rsp_wait_reached", icb_rsp_rdy, 1);
    chk("rsp_wait_busy", busy, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    chk_reset_vals("midrst");
    rsp_hold = 1'b0;
    rst = 1'b0;
    @(negedge clk); #1;
    chk_reset_vals("postrst");
    chk("rst_cmd_consumed", exp_cmd.size(), 0);
    rsp_q.delete();
    @(negedge clk);

    // Recovery read after reset
    exp_icb(1'b1, 32'h0000_0008, 32'h0, 32'h0BAD_F00D, 1'b0);
    fr = '{8'h00, 8'h0D, 8'hF0, 8'hAD, 8'h0B}; exp_bytes(fr);
    fr = '{8'h5A, 8'h08, 8'h00, 8'h00, 8'h00}; send_q(fr);
    drain("recover_drain");

    repeat (3) @(negedge clk);
    chk("end_rsp_q_empty", rsp_q.size(), 0);
    chk("end_perr_pending", exp_perr, 0);
    chk("end_idle", busy, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
